// File: rtl/sram_wr_sequencer.sv
// Frame-buffer SRAM write sequencer: maps CASET/RASET windows and RAMWR strobes to linear writes, and runs SWRESET clears.
// Optional feature macro: SRAM_WR_CLIP_EN (suppress writes whose pointer lies outside the panel).
module sram_wr_sequencer #(
   parameter int          H_RES     = 160,
   parameter int          V_RES     = 128,
   parameter int          AW        = 15,
   parameter logic [15:0] CLR_COLOR = 16'h0000
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr_req,
   input  logic          i_write_req,
   input  logic          i_waddr_set_req,
   input  logic [15:0]   i_pixel_data,
   input  logic [31:0]   i_col_addr,
   input  logic [31:0]   i_row_addr,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [15:0]   o_mem_wdata,
   input  logic          i_mem_ready,
   output logic          o_busy,
   output logic          o_overflow
);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);

   state_t        state_q, state_d;
   logic          clr_r_q, wr_r_q, ws_r_q;
   logic [15:0]   xs_q, xe_q, ys_q, ye_q;
   logic [15:0]   xs_d, xe_d, ys_d, ye_d;
   logic [15:0]   x_q, y_q, x_d, y_d;
   logic [15:0]   buf_q, buf_d;
   logic          buf_full_q, buf_full_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;

   logic          clr_edge, wr_edge, ws_edge;
   logic          start_clr, take, accept, adv;
   logic [15:0]   xe_eff, ye_eff;

   // Linear address y*H_RES + x, formed in AW+1 bits and truncated to the port width.
   function automatic logic [AW-1:0] lin_addr(input logic [15:0] x, input logic [15:0] y);
      logic [AW:0] full;
      full = (AW+1)'(y) * (AW+1)'(H_RES) + (AW+1)'(x);
      return AW'(full);
   endfunction

`ifdef SRAM_WR_CLIP_EN
   function automatic logic in_panel(input logic [15:0] x, input logic [15:0] y);
      return (x < 16'(H_RES)) && (y < 16'(V_RES));
   endfunction
`endif

   always_comb begin
      clr_edge   = i_clr_req & ~clr_r_q;
      wr_edge    = i_write_req & ~wr_r_q;
      ws_edge    = i_waddr_set_req & ~ws_r_q;
      // An inverted window collapses to a single fixed column/row at the start coordinate.
      xe_eff     = (xs_q > xe_q) ? xs_q : xe_q;
      ye_eff     = (ys_q > ye_q) ? ys_q : ye_q;

      state_d    = state_q;
      xs_d       = xs_q;
      xe_d       = xe_q;
      ys_d       = ys_q;
      ye_d       = ye_q;
      x_d        = x_q;
      y_d        = y_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ovf_d      = ovf_q;
      start_clr  = 1'b0;
      take       = 1'b0;
      adv        = 1'b0;
`ifdef SRAM_WR_CLIP_EN
      accept     = we_q ? i_mem_ready : 1'b1;
`else
      accept     = i_mem_ready;
`endif

      case (state_q)
         IDLE: begin
            if (clr_edge) begin
               start_clr = 1'b1;
            end else if (buf_full_q) begin
               // The buffered pixel moves into the output registers, freeing the buffer.
               state_d    = WRITE;
               take       = 1'b1;
               buf_full_d = 1'b0;
               addr_d     = lin_addr(x_q, y_q);
               wdata_d    = buf_q;
`ifdef SRAM_WR_CLIP_EN
               we_d       = in_panel(x_q, y_q);
`else
               we_d       = 1'b1;
`endif
            end
         end
         WRITE: begin
            if (clr_edge) begin
               start_clr = 1'b1;
            end else if (accept) begin
               state_d = IDLE;
               we_d    = 1'b0;
               adv     = 1'b1;
            end
         end
         CLEAR: begin
            if (clr_edge) begin
               start_clr = 1'b1;
            end else if (i_mem_ready) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = IDLE;
                  we_d    = 1'b0;
                  x_d     = xs_q;
                  y_d     = ys_q;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            we_d    = 1'b0;
         end
      endcase

      if (start_clr) begin
         state_d    = CLEAR;
         we_d       = 1'b1;
         addr_d     = '0;
         wdata_d    = CLR_COLOR;
         buf_full_d = 1'b0;
         ovf_d      = 1'b0;
      end

      // Pixel edges are ignored while clearing or when a clear starts this cycle.
      if (wr_edge && (state_q != CLEAR) && !start_clr) begin
         if (!buf_full_q || take) begin
            buf_d      = i_pixel_data;
            buf_full_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (adv) begin
         if (x_q == xe_eff) begin
            x_d = xs_q;
            y_d = (y_q == ye_eff) ? ys_q : y_q + 16'd1;
         end else begin
            x_d = x_q + 16'd1;
         end
      end

      // A window set overrides any pointer update made in the same cycle.
      if (ws_edge) begin
         xs_d = i_col_addr[31:16];
         xe_d = i_col_addr[15:0];
         ys_d = i_row_addr[31:16];
         ye_d = i_row_addr[15:0];
         x_d  = i_col_addr[31:16];
         y_d  = i_row_addr[31:16];
      end

      busy_d = (state_d != IDLE) || buf_full_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         clr_r_q    <= 1'b0;
         wr_r_q     <= 1'b0;
         ws_r_q     <= 1'b0;
         xs_q       <= '0;
         xe_q       <= 16'(H_RES - 1);
         ys_q       <= '0;
         ye_q       <= 16'(V_RES - 1);
         x_q        <= '0;
         y_q        <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_r_q    <= i_clr_req;
         wr_r_q     <= i_write_req;
         ws_r_q     <= i_waddr_set_req;
         xs_q       <= xs_d;
         xe_q       <= xe_d;
         ys_q       <= ys_d;
         ye_q       <= ye_d;
         x_q        <= x_d;
         y_q        <= y_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
      end
   end

   assign o_mem_we    = we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_busy      = busy_q;
   assign o_overflow  = ovf_q;

endmodule
